// File: rtl/nn_axil_pkg.sv
// Shared constants and types for the AXI4-Lite layer controller: register map,
// CTRL/STATUS bit positions and the layer FSM encoding.
package nn_axil_pkg;

   localparam logic [4:0] OFF_OP0    = 5'h00;
   localparam logic [4:0] OFF_OP1    = 5'h04;
   localparam logic [4:0] OFF_OP2    = 5'h08;
   localparam logic [4:0] OFF_OP3    = 5'h0C;
   localparam logic [4:0] OFF_CTRL   = 5'h10;
   localparam logic [4:0] OFF_STATUS = 5'h14;
   localparam logic [4:0] OFF_RESULT = 5'h18;

   localparam int unsigned CTRL_START_BIT  = 0;
   localparam int unsigned CTRL_CLR_BIT    = 1;
   localparam int unsigned STATUS_BUSY_BIT = 0;
   localparam int unsigned STATUS_DONE_BIT = 1;

   typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} layer_state_e;

   // Byte address bits [1:0] never select anything.
   function automatic logic [4:0] word_off(input logic [4:0] addr);
      return {addr[4:2], 2'b00};
   endfunction

endpackage

// File: rtl/nn_axil_layer_ctrl_if.sv
// AXI4-Lite bus bundle between the master VIP / interconnect and the layer controller.
interface nn_axil_layer_ctrl_if #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 32
);
   logic [ADDR_W-1:0]   S_AXI_AWADDR;
   logic [2:0]          S_AXI_AWPROT;
   logic                S_AXI_AWVALID;
   logic                S_AXI_AWREADY;
   logic [DATA_W-1:0]   S_AXI_WDATA;
   logic [DATA_W/8-1:0] S_AXI_WSTRB;
   logic                S_AXI_WVALID;
   logic                S_AXI_WREADY;
   logic [1:0]          S_AXI_BRESP;
   logic                S_AXI_BVALID;
   logic                S_AXI_BREADY;
   logic [ADDR_W-1:0]   S_AXI_ARADDR;
   logic [2:0]          S_AXI_ARPROT;
   logic                S_AXI_ARVALID;
   logic                S_AXI_ARREADY;
   logic [DATA_W-1:0]   S_AXI_RDATA;
   logic [1:0]          S_AXI_RRESP;
   logic                S_AXI_RVALID;
   logic                S_AXI_RREADY;

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB,
             S_AXI_WVALID, S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
             S_AXI_RREADY,
      output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
             S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );

   modport master (
      output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB,
             S_AXI_WVALID, S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
             S_AXI_RREADY,
      input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
             S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );

endinterface

// File: rtl/nn_axil_regbank.sv
// AXI4-Lite slave handshakes plus the operand register file; emits CTRL strobes and
// muxes STATUS/RESULT supplied by the controller into the read path.
module nn_axil_regbank
   import nn_axil_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   nn_axil_layer_ctrl_if.slave     s_axi,
   output logic [4*DATA_WIDTH-1:0] o_operands,
   output logic                    o_start_pulse,
   output logic                    o_clr_pulse,
   input  logic [DATA_WIDTH-1:0]   i_status,
   input  logic [DATA_WIDTH-1:0]   i_result
);

   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   logic                  r_aw_full, r_w_full, r_bvalid, r_rvalid;
   logic [ADDR_WIDTH-1:0] r_awaddr;
   logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
   logic [STRB_WIDTH-1:0] r_wstrb;
   logic [DATA_WIDTH-1:0] r_op [4];

   logic                  w_aw_hs, w_w_hs, w_ar_hs, w_commit;
   logic [4:0]            w_aw_off, w_ar_off;
   logic [3:0]            w_op_we;
   logic [DATA_WIDTH-1:0] w_strb_mask, w_rd_mux;
   logic                  w_unused;

   assign w_unused = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};

   // Readies are forced low during reset so every output reads 0 while ARESET is high.
   assign s_axi.S_AXI_AWREADY = ~rst & ~r_aw_full & ~r_bvalid;
   assign s_axi.S_AXI_WREADY  = ~rst & ~r_w_full & ~r_bvalid;
   assign s_axi.S_AXI_ARREADY = ~rst & ~r_rvalid;
   assign s_axi.S_AXI_BRESP   = 2'b00;
   assign s_axi.S_AXI_BVALID  = r_bvalid;
   assign s_axi.S_AXI_RDATA   = r_rdata;
   assign s_axi.S_AXI_RRESP   = 2'b00;
   assign s_axi.S_AXI_RVALID  = r_rvalid;

   assign w_aw_hs  = s_axi.S_AXI_AWVALID & s_axi.S_AXI_AWREADY;
   assign w_w_hs   = s_axi.S_AXI_WVALID & s_axi.S_AXI_WREADY;
   assign w_ar_hs  = s_axi.S_AXI_ARVALID & s_axi.S_AXI_ARREADY;
   assign w_commit = r_aw_full & r_w_full;
   assign w_aw_off = word_off(r_awaddr[4:0]);
   assign w_ar_off = word_off(s_axi.S_AXI_ARADDR[4:0]);

   assign o_start_pulse = w_commit & (w_aw_off == OFF_CTRL) & r_wstrb[0]
                          & r_wdata[CTRL_START_BIT];
   assign o_clr_pulse   = w_commit & (w_aw_off == OFF_CTRL) & r_wstrb[0]
                          & r_wdata[CTRL_CLR_BIT];
   assign o_operands    = {r_op[3], r_op[2], r_op[1], r_op[0]};

   always_comb begin
      w_strb_mask = '0;
      for (int b = 0; b < int'(STRB_WIDTH); b++) begin
         w_strb_mask[8*b +: 8] = {8{r_wstrb[b]}};
      end
   end

   always_comb begin
      w_op_we = '0;
      if (w_commit) begin
         case (w_aw_off)
            OFF_OP0: w_op_we[0] = 1'b1;
            OFF_OP1: w_op_we[1] = 1'b1;
            OFF_OP2: w_op_we[2] = 1'b1;
            OFF_OP3: w_op_we[3] = 1'b1;
            default: w_op_we = '0;
         endcase
      end
   end

   // Sampled from the current registers, so a same-cycle write is not yet visible.
   always_comb begin
      w_rd_mux = '0;
      case (w_ar_off)
         OFF_OP0:    w_rd_mux = r_op[0];
         OFF_OP1:    w_rd_mux = r_op[1];
         OFF_OP2:    w_rd_mux = r_op[2];
         OFF_OP3:    w_rd_mux = r_op[3];
         OFF_STATUS: w_rd_mux = i_status;
         OFF_RESULT: w_rd_mux = i_result;
         default:    w_rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_aw_full <= 1'b0;
         r_w_full  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_rvalid  <= 1'b0;
         r_awaddr  <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_rdata   <= '0;
      end else begin
         if (w_aw_hs) begin
            r_aw_full <= 1'b1;
            r_awaddr  <= s_axi.S_AXI_AWADDR;
         end
         if (w_w_hs) begin
            r_w_full <= 1'b1;
            r_wdata  <= s_axi.S_AXI_WDATA;
            r_wstrb  <= s_axi.S_AXI_WSTRB;
         end
         if (w_commit) begin
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_bvalid  <= 1'b1;
         end else if (s_axi.S_AXI_BREADY) begin
            r_bvalid <= 1'b0;
         end
         if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_mux;
         end else if (s_axi.S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) r_op[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (w_op_we[i]) r_op[i] <= (r_op[i] & ~w_strb_mask) | (r_wdata & w_strb_mask);
         end
      end
   end

endmodule

// File: rtl/nn_axil_layer_ctrl.sv
// AXI4-Lite layer controller: snapshots operands on START, hands them to the compute
// core over valid/ready, captures the result and reports busy/done.
module nn_axil_layer_ctrl
   import nn_axil_pkg::*;
#(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
   parameter int unsigned C_NUM_OPERANDS     = 4
) (
   input  logic                                         ACLK,
   input  logic                                         ARESET,
   nn_axil_layer_ctrl_if.slave                          s_axi,
   output logic [C_NUM_OPERANDS*C_S_AXI_DATA_WIDTH-1:0] op_data,
   output logic                                         op_valid,
   input  logic                                         op_ready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]                res_data,
   input  logic                                         res_valid
);

   logic [C_NUM_OPERANDS*C_S_AXI_DATA_WIDTH-1:0] w_operands, r_op_data;
   logic [C_S_AXI_DATA_WIDTH-1:0]                w_status, r_result;
   logic                                         w_start, w_clr, w_snapshot;
   layer_state_e                                 r_state, w_state_next;

   nn_axil_regbank #(
      .DATA_WIDTH (C_S_AXI_DATA_WIDTH),
      .ADDR_WIDTH (C_S_AXI_ADDR_WIDTH)
   ) u_regbank (
      .clk           (ACLK),
      .rst           (ARESET),
      .s_axi         (s_axi),
      .o_operands    (w_operands),
      .o_start_pulse (w_start),
      .o_clr_pulse   (w_clr),
      .i_status      (w_status),
      .i_result      (r_result)
   );

   assign w_snapshot = w_start & ((r_state == IDLE) | (r_state == DONE));
   assign op_valid   = (r_state == SEND);
   assign op_data    = r_op_data;

   always_comb begin
      w_status                  = '0;
      w_status[STATUS_BUSY_BIT] = (r_state == SEND) | (r_state == WAIT);
      w_status[STATUS_DONE_BIT] = (r_state == DONE);
   end

   // START outranks CLR_DONE when both arrive in one write.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_start) w_state_next = SEND;
         SEND:    if (op_ready) w_state_next = WAIT;
         WAIT:    if (res_valid) w_state_next = DONE;
         DONE: begin
            if (w_start)    w_state_next = SEND;
            else if (w_clr) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_state   <= IDLE;
         r_op_data <= '0;
         r_result  <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_snapshot) r_op_data <= w_operands;
         if ((r_state == WAIT) && res_valid) r_result <= res_data;
      end
   end

endmodule
